// File: rtl/io_pattern_pkg.sv
// rtl/io_pattern_pkg.sv - shared types, default sizes and length helper for the pad pattern generator
package io_pattern_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_HOLD_W = 16;

  // Number of entries actually played: requested length capped at the memory size.
  function automatic int clamp_len(input int req_len, input int depth);
    return (req_len > depth) ? depth : req_len;
  endfunction

endpackage

// File: rtl/io_pattern_ram.sv
// rtl/io_pattern_ram.sv - pattern storage, one synchronous write port and one asynchronous read port
module io_pattern_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; firmware always loads before playing.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/io_pattern_gen.sv
// rtl/io_pattern_gen.sv - steps a programmed byte sequence onto the user pads at a fixed hold cadence
module io_pattern_gen
  import io_pattern_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]         cfg_data,
  input  logic [$clog2(DEPTH):0]   seq_len,
  input  logic [HOLD_W-1:0]        hold_cycles,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic [WIDTH-1:0]         io_out,
  output logic [WIDTH-1:0]         io_oeb,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  state_t            state, state_next;
  logic [AW-1:0]     idx, last_idx, rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic [HOLD_W-1:0] hold_cnt, hold_reload, hold_start;
  logic [LW-1:0]     n_len;
  logic              loop_r;
  logic              start_ok, hold_end, at_last;

  assign n_len      = LW'(clamp_len(int'(seq_len), DEPTH));
  assign hold_start = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);
  assign start_ok   = start && !stop && (seq_len != '0);
  assign hold_end   = (hold_cnt == '0);
  assign at_last    = (idx == last_idx);

  // The single read port always points at whatever entry loads at the next edge.
  assign rd_addr = (state == RUN && !at_last) ? idx + AW'(1) : '0;

  io_pattern_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clock) begin
    if (!resetb) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = RUN;
      RUN: begin
        if (stop)                                  state_next = IDLE;
        else if (hold_end && at_last && !loop_r)   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // Once enabled, the pads stay driven with the last value until reset.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      io_out      <= '0;
      io_oeb      <= '1;
      done        <= 1'b0;
      idx         <= '0;
      last_idx    <= '0;
      hold_cnt    <= '0;
      hold_reload <= '0;
      loop_r      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            last_idx    <= AW'(n_len - LW'(1));
            hold_reload <= hold_start;
            hold_cnt    <= hold_start;
            loop_r      <= loop;
            idx         <= '0;
            io_out      <= rd_data;
            io_oeb      <= '0;
          end
        end
        RUN: begin
          if (!stop) begin
            if (hold_end) begin
              if (!at_last || loop_r) begin
                idx      <= at_last ? '0 : idx + AW'(1);
                io_out   <= rd_data;
                hold_cnt <= hold_reload;
              end else begin
                done <= 1'b1;
              end
            end else begin
              hold_cnt <= hold_cnt - HOLD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign step_idx = idx;

endmodule

// File: doc/io_pattern_gen.md
# io_pattern_gen

User-area pattern generator that drives a programmed sequence of 8-bit values onto the low Caravel user I/O pads (`mprj_io[7:0]`) without firmware bit-banging. Firmware or a test harness loads up to DEPTH words into a small pattern memory, sets a length and a per-step hold time, then pulses `start`. The block steps through the sequence at a fixed cadence, optionally looping, and owns the pad output enables. The chip-level I/O-port monitor bench consumes its output directly.

## Interface
- `WIDTH`, 8: pad bits driven.
- `DEPTH`, 16: pattern memory entries; power of two, at least 2.
- `HOLD_W`, 16: width of the hold-cycle count.

- `clock`  in  1  : single clock; all logic is on the rising edge.
- `resetb`  in  1  : reset, synchronous and active-low.
- `cfg_we`  in  1  : pattern memory write strobe.
- `cfg_addr`  in  $clog2(DEPTH)  : write address.
- `cfg_data`  in  WIDTH  : write data.
- `seq_len`  in  $clog2(DEPTH)+1  : number of entries to play; latched at `start`.
- `hold_cycles`  in  HOLD_W  : cycles each entry is held; latched at `start`; 0 is treated as 1.
- `loop`  in  1  : 1 = wrap to entry 0 after the last entry; latched at `start`.
- `start`  in  1  : single-cycle start pulse.
- `stop`  in  1  : single-cycle abort pulse.
- `io_out`  out  WIDTH  : pad output value.
- `io_oeb`  out  WIDTH  : pad output enables, active-low; all bits equal.
- `busy`  out  1  : sequence running.
- `done`  out  1  : one-cycle pulse on normal completion.
- `step_idx`  out  $clog2(DEPTH)  : index of the entry currently on `io_out`.

## Operation
- Reset values: `io_out`=0, `io_oeb`=all 1s, `busy`=0, `done`=0, `step_idx`=0, state IDLE. Pattern memory is not reset.
- States: IDLE, RUN.
- IDLE→RUN: `start`=1, `stop`=0, latched length N≠0.
  - N is `seq_len` clamped to DEPTH.
  - H is max(`hold_cycles`, 1).
  - Entry 0 loads; `io_oeb` goes to 0.
- `start` with `seq_len`=0 is ignored: no state change, no `done`.
- RUN: a hold counter counts H cycles per entry. At the end of the hold:
  - If index < N−1: increment the index and load the next entry.
  - Else if `loop`: wrap the index to 0 and load entry 0.
  - Else: go to IDLE and pulse `done`.
- RUN→IDLE on `stop`: takes effect at the next edge, no `done`.
- Leaving RUN, by completion or by `stop`: `io_out` keeps its last value and `io_oeb` stays 0.
  - The pads remain driven until reset.
- `start` while RUN is ignored.
- `start` and `stop` in the same cycle: `stop` wins.
- `cfg_we` is accepted in any state. The memory is sampled only when an entry loads.
  - A write to the entry currently displayed changes the pad value at that entry's next load, not immediately.
  - A write and a load of the same address in the same cycle: the load sees the old data.
- `resetb` low mid-run: all outputs return to reset values at that edge. Latched parameters are discarded.

## Timing
- `start` sampled at edge k:
  - `io_out`=mem[0], `busy`=1 and `io_oeb`=0 are all valid after edge k.
  - Entry i appears after edge k + i·H.
- Non-loop completion: after edge k + N·H, `busy`=0 and `done`=1 for exactly one cycle.
  - `io_out` still shows mem[N−1].
- `stop` sampled at edge j: `busy`=0 after edge j. `io_out` is frozen from edge j.
- `io_out` and `io_oeb` are registered outputs with no combinational path from inputs.
- Hold counter is HOLD_W bits, counts down from H−1.
  - H = 2^HOLD_W − 1 must work.
  - `hold_cycles`=0 and `hold_cycles`=1 give identical timing.

## Structure
- Package `io_pattern_pkg` holds:
  - the state enum (IDLE, RUN);
  - the default WIDTH/DEPTH/HOLD_W constants;
  - the helper that derives N from `seq_len`.
- Sub-module `io_pattern_ram`: DEPTH×WIDTH register array, one synchronous write port, one asynchronous read port.
- The FSM, hold counter and index counter live in `io_pattern_gen`.

## Test plan
- Load 01,02,…,0A,FF,00 at addresses 0–11; `seq_len`=12, `hold_cycles`=4, `loop`=0; pulse `start`.
  - Each value appears for exactly 4 cycles, in order.
  - `done` pulses once, 48 cycles after `start`.
  - `io_out` stays 00 and `io_oeb` stays 00 afterwards.
- Same load, `loop`=1, `hold_cycles`=0.
  - One value per cycle; after 0x00 the next cycle shows 0x01.
  - `busy` stays high; `done` never asserts.
  - Then pulse `stop` while 0x05 is shown: `busy`=0 next cycle and `io_out` holds 0x05.
- `seq_len`=0 with `start`: no `busy`, no `done`, `io_oeb` stays FF.
- `seq_len`=31 (beyond DEPTH=16): plays exactly 16 entries, then `done`.
- Mid-run write to address 2 while entry 2 is displayed with `loop`=1: the current value is unchanged; the new value appears on the next pass.
- Assert `resetb`=0 mid-sequence, `start` and `stop` in the same cycle, and `start` while `busy`.
  - Reset: `io_out`=00, `io_oeb`=FF, `busy`=0 after the edge.
  - Simultaneous `start`/`stop`: block stays IDLE.
  - `start` while `busy`: sequence timing is unaffected.
